// File: rtl/instr_realign_fifo.sv
// Purpose : fetch-side word FIFO that realigns the halfword stream into one
//           compressed or 32-bit instruction (with PC and bus-error flag) per handshake.
// Latency : a pushed word is visible on the outputs the cycle after the push (no bypass).
// Backpressure: in_ready_o depends only on the occupancy count, so a full buffer
//           refuses a push even when a pop happens in the same cycle.
// Ports   : clk_i/rst_ni clock and async active-low reset; clear_i/branch_addr_i flush and redirect;
//           in_valid_i/in_ready_o/in_rdata_i/in_err_i fetch side; out_valid_o/out_ready_i/
//           out_addr_o/out_rdata_o/out_err_o decoder side.
module instr_realign_fifo #(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] branch_addr_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_addr_o,
  output logic [31:0] out_rdata_o,
  output logic        out_err_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]      mem_q [DEPTH];
  logic [DEPTH-1:0] err_q, err_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr1;
  logic [CW-1:0]    count_q, count_d;
  logic [31:0]      pc_q, pc_d;

  logic [31:0] word0;
  logic [15:0] word1_lo;
  logic        err0, err1, cnt_ge1, cnt_ge2, unaligned, comp;
  logic        valid, push, pop, deq;
  logic [31:0] rdata;
  logic        err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else return p + PW'(1);
  endfunction

  assign rd_ptr1   = ptr_inc(rd_ptr_q);
  assign word0     = mem_q[rd_ptr_q];
  assign word1_lo  = mem_q[rd_ptr1][15:0];
  assign err0      = err_q[rd_ptr_q];
  assign err1      = err_q[rd_ptr1];
  assign cnt_ge1   = (count_q != '0);
  assign cnt_ge2   = (count_q >= CW'(2));
  assign unaligned = pc_q[1];
  assign comp      = unaligned ? (word0[17:16] != 2'b11) : (word0[1:0] != 2'b11);

  // Output assembly; everything here is a function of registered state only.
  always_comb begin
    valid = 1'b0;
    rdata = '0;
    err   = 1'b0;
    if (!unaligned) begin
      valid = cnt_ge1;
      rdata = comp ? {16'h0, word0[15:0]} : word0;
      err   = err0;
    end else if (comp) begin
      valid = cnt_ge1;
      rdata = {16'h0, word0[31:16]};
      err   = err0;
    end else begin
      // A bus error on the lone head word is reported without waiting for the
      // second half, which may never arrive.
      valid = cnt_ge2 || (cnt_ge1 && err0);
      rdata = {(cnt_ge2 ? word1_lo : 16'h0), word0[31:16]};
      err   = err0 | (cnt_ge2 & err1);
    end
  end

  assign in_ready_o  = (count_q < CW'(DEPTH));
  assign out_valid_o = valid;
  assign out_rdata_o = valid ? rdata : 32'h0;
  assign out_err_o   = valid ? err : 1'b0;
  assign out_addr_o  = pc_q;

  assign push = in_valid_i && in_ready_o && !clear_i;
  assign pop  = valid && out_ready_i && !clear_i;
  // An aligned compressed instruction only consumes the low half of the head word.
  assign deq  = pop && !(!unaligned && comp);

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    pc_d     = pc_q;
    err_d    = err_q;
    if (clear_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      pc_d     = branch_addr_i & ~32'h1;
      err_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d        = ptr_inc(wr_ptr_q);
        err_d[wr_ptr_q] = in_err_i;
      end
      if (deq) rd_ptr_d = rd_ptr1;
      if (pop) pc_d = pc_q + (comp ? 32'd2 : 32'd4);
      case ({push, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      pc_q     <= '0;
      err_q    <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
    end
  end

  // Word storage needs no reset: it is only observed through count-qualified paths.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_rdata_i;
  end

endmodule

// File: tb/tb_instr_realign_fifo.sv
module tb_instr_realign_fifo;
  localparam int unsigned DEPTH = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic [31:0] branch_addr_i;
  logic        in_valid_i;
  logic [31:0] in_rdata_i;
  logic        in_err_i;
  logic        in_ready_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_addr_o;
  logic [31:0] out_rdata_o;
  logic        out_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  instr_realign_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .branch_addr_i(branch_addr_i),
    .in_valid_i(in_valid_i), .in_rdata_i(in_rdata_i), .in_err_i(in_err_i),
    .in_ready_o(in_ready_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o), .out_rdata_o(out_rdata_o), .out_err_o(out_err_o)
  );

  // Observed bundle: {valid, addr, rdata, err, in_ready}
  function automatic logic [66:0] obs();
    return {out_valid_o, out_addr_o, out_rdata_o, out_err_o, in_ready_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_clear(input logic [31:0] a);
    clear_i = 1'b1; branch_addr_i = a; tick(); clear_i = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] w, input logic e);
    in_valid_i = 1'b1; in_rdata_i = w; in_err_i = e; tick();
    in_valid_i = 1'b0; in_err_i = 1'b0;
  endtask

  task automatic do_pop();
    out_ready_i = 1'b1; tick(); out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [66:0] exp_v;
    exp_v = {1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    rst_ni = 1'b1;
    tick();
    do_push(32'h0000_0013, 1'b0);
    do_push(32'h0010_0013, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL reset_held: got %h want %h", obs(), exp_v);
    end
    tick();
    rst_ni = 1'b1;
    tick();
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL reset_released: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_aligned32();
    logic [66:0] exp_v;
    do_clear(32'h100);
    do_push(32'h00B5_0513, 1'b0);
    exp_v = {1'b1, 32'h100, 32'h00B5_0513, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL aligned32_present: got %h want %h", obs(), exp_v);
    end
    do_pop();
    exp_v = {1'b0, 32'h104, 32'h0, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL aligned32_pop: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_compressed();
    logic [66:0] exp_v;
    do_clear(32'h200);
    do_push(32'h4585_4501, 1'b0);
    exp_v = {1'b1, 32'h200, 32'h0000_4501, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL comp_first: got %h want %h", obs(), exp_v);
    end
    do_pop();
    exp_v = {1'b1, 32'h202, 32'h0000_4585, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL comp_second: got %h want %h", obs(), exp_v);
    end
    do_pop();
    exp_v = {1'b0, 32'h204, 32'h0, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL comp_drained: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_unaligned();
    logic [66:0] exp_v;
    do_clear(32'h302);
    do_push(32'h0513_0000, 1'b0);
    exp_v = {1'b0, 32'h302, 32'h0, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL unaligned_wait: got %h want %h", obs(), exp_v);
    end
    do_push(32'h0000_00B5, 1'b0);
    exp_v = {1'b1, 32'h302, 32'h00B5_0513, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL unaligned_span: got %h want %h", obs(), exp_v);
    end
    do_pop();
    // One word left, PC still unaligned; its upper half 0x0000 is compressed.
    exp_v = {1'b1, 32'h306, 32'h0000_0000, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL unaligned_after_pop: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_fetch_err();
    logic [66:0] exp_v;
    do_clear(32'h402);
    do_push(32'hFFFF_0000, 1'b1);
    exp_v = {1'b1, 32'h402, 32'h0000_FFFF, 1'b1, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL fetch_err: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_wrap();
    logic [66:0] exp_v;
    do_clear(32'hFFFF_FFFF);
    do_push(32'h0001_0000, 1'b0);
    exp_v = {1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL wrap_present: got %h want %h", obs(), exp_v);
    end
    do_pop();
    exp_v = {1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL wrap_pc: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_full_flush();
    logic [66:0] exp_v;
    do_clear(32'h500);
    do_push(32'h0000_0013, 1'b0);
    do_push(32'h0010_0013, 1'b0);
    do_push(32'h0020_0013, 1'b0);
    exp_v = {1'b1, 32'h500, 32'h0000_0013, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL full_ready: got %h want %h", obs(), exp_v);
    end
    do_push(32'hDEAD_BEEF, 1'b0);
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL full_ignore: got %h want %h", obs(), exp_v);
    end
    in_valid_i = 1'b1; in_rdata_i = 32'h1111_1113; out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    exp_v = {1'b1, 32'h504, 32'h0010_0013, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL full_pop_only: got %h want %h", obs(), exp_v);
    end
    do_pop();
    exp_v = {1'b1, 32'h508, 32'h0020_0013, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL full_third: got %h want %h", obs(), exp_v);
    end
    do_pop();
    exp_v = {1'b0, 32'h50C, 32'h0, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL full_refused_dropped: got %h want %h", obs(), exp_v);
    end
    do_push(32'h0030_0013, 1'b1);
    clear_i = 1'b1; branch_addr_i = 32'h600; in_valid_i = 1'b1; in_rdata_i = 32'h0040_0013;
    out_ready_i = 1'b1;
    tick();
    clear_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    exp_v = {1'b0, 32'h600, 32'h0, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL flush_clear: got %h want %h", obs(), exp_v);
    end
    tick();
    n_cmp++;
    if (obs() !== exp_v) begin
      n_bad++; $display("FAIL flush_push_dropped: got %h want %h", obs(), exp_v);
    end
  endtask

  // Reference model: a queue of pending halfwords {err, half}; instructions are
  // carved from its front. A pending low-half skip covers unaligned PCs with no
  // buffered word.
  task automatic test_random();
    logic [16:0] hq[$];
    logic [31:0] m_pc;
    bit          m_drop;
    logic [66:0] exp_v;
    logic        ev, ee, er, comp;
    logic [31:0] ed, w;
    logic [16:0] h0, h1;
    logic        cl, iv, ie, ordy;
    logic [31:0] ba;
    do_clear(32'h0);
    m_pc = 32'h0; m_drop = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ev = 1'b0; ed = 32'h0; ee = 1'b0; comp = 1'b0;
      if (hq.size() > 0) begin
        h0 = hq[0];
        comp = (h0[1:0] != 2'b11);
        if (comp) begin
          ev = 1'b1; ed = {16'h0, h0[15:0]}; ee = h0[16];
        end else if (hq.size() >= 2) begin
          h1 = hq[1];
          ev = 1'b1; ed = {h1[15:0], h0[15:0]}; ee = h0[16] | h1[16];
        end else if (h0[16]) begin
          ev = 1'b1; ed = {16'h0, h0[15:0]}; ee = 1'b1;
        end
      end
      er = ((hq.size() + 1) / 2) < DEPTH;
      exp_v = {ev, m_pc, ed, ee, er};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++; $display("FAIL random_cyc%0d: got %h want %h", cyc, obs(), exp_v);
      end

      cl = ($urandom_range(39) == 0);
      ba = ($urandom_range(3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(7))) : $urandom;
      iv = ($urandom_range(9) < 6);
      w = $urandom;
      if ($urandom_range(1) == 1) w[1:0] = 2'b11;
      if ($urandom_range(1) == 1) w[17:16] = 2'b11;
      ie = ($urandom_range(9) == 0);
      ordy = ($urandom_range(9) < 7);
      clear_i = cl; branch_addr_i = ba; in_valid_i = iv; in_rdata_i = w; in_err_i = ie;
      out_ready_i = ordy;

      if (cl) begin
        hq.delete();
        m_pc = ba & ~32'h1;
        m_drop = ba[1];
      end else begin
        if (ev && ordy) begin
          if (comp) begin
            void'(hq.pop_front());
            m_pc = m_pc + 32'd2;
          end else begin
            if (hq.size() >= 2) begin
              void'(hq.pop_front());
              void'(hq.pop_front());
            end else begin
              void'(hq.pop_front());
              m_drop = 1'b1;
            end
            m_pc = m_pc + 32'd4;
          end
        end
        if (iv && er) begin
          if (m_drop) m_drop = 1'b0;
          else hq.push_back({ie, w[15:0]});
          hq.push_back({ie, w[31:16]});
        end
      end
      tick();
    end
    clear_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_err_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; branch_addr_i = 32'h0; in_valid_i = 1'b0;
    in_rdata_i = 32'h0; in_err_i = 1'b0; out_ready_i = 1'b0;
    tick();
    test_reset();
    test_aligned32();
    test_compressed();
    test_unaligned();
    test_fetch_err();
    test_wrap();
    test_full_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
